// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IDLE    = 4'd10,
    S_TRAP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore control word; 17 bits wide.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  // States whose exit edge completes (retires) an instruction.
  function automatic logic retires(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RTYPEWB) ||
           (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Purely combinational Moore output decode: current state -> control word.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]  i_state,
  output logic [16:0] o_ctrl
);

  state_t w_state;
  ctrl_t  w_ctrl;

  assign w_state = state_t'(i_state);
  assign o_ctrl  = w_ctrl;

  // Every field defaults to 0; each state raises only its own controls.
  always_comb begin
    w_ctrl = '0;
    case (w_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.pc_write  = 1'b1;
      end
      S_DECODE: w_ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
      S_TRAP:  w_ctrl.halted = 1'b1;
      default: w_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: state sequencing, opcode latch,
// retired-instruction counter and sticky trap on unsupported opcodes.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount,
  output logic             Halted
);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_opcode;
  logic [CNT_W-1:0] r_count;
  logic [16:0]      w_ctrl_vec;
  ctrl_t            w_ctrl;

  mips_ctrl_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl_vec)
  );

  assign w_ctrl = ctrl_t'(w_ctrl_vec);

  // State and counter; reset aborts any in-flight instruction uncounted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (retires(r_state)) r_count <= r_count + CNT_W'(1);
    end
  end

  // Capture the opcode on the DECODE exit edge so MEMADR ignores later IR changes.
  always_ff @(posedge clock) begin
    if (r_state == S_DECODE) r_opcode <= Opcode;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:  w_next = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_MEMWB, S_MEMWR, S_RTYPEWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_EXEC:    w_next = S_RTYPEWB;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_TRAP;
    endcase
  end

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign PCEn        = w_ctrl.pc_write | (w_ctrl.pc_write_cond & Zero);
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign RegDst      = w_ctrl.reg_dst;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign Halted      = w_ctrl.halted;
  assign State       = r_state;
  assign InstrCount  = r_count;

endmodule
